// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider -- 8-bit unsigned restoring divider, one quotient bit per clock.
//
// A rising edge with rst=1 clears the outputs and captures the operands; every
// following edge performs one restoring iteration, MSB first. The result
// appears on the 8th edge with rst=0 and is held until the next rst.
// Division by zero falls out of the datapath naturally: the shifted divisor is
// always 0, every compare succeeds, and the result is quo=8'hFF, rem=a.
//
// Ports
//   clk   in   1  clock, rising edge
//   rst   in   1  synchronous active-high reset; also starts a new division
//   a     in   8  dividend, unsigned (sampled only while rst=1)
//   b     in   8  divisor, unsigned (sampled only while rst=1)
//   quo   out  8  quotient, registered, 0 until the result is ready
//   rem   out  8  remainder, registered, 0 until the result is ready
//   done  out  1  high while quo/rem hold the result of the captured operands
// -----------------------------------------------------------------------------
module divider (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] quo,
   output logic [7:0] rem,
   output logic       done
);

   localparam logic [1:0] ST_LOAD = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [15:0] prem_q,  prem_d;   // partial remainder
   logic [15:0] dvsr_q,  dvsr_d;   // divisor, shifted right each iteration
   logic [7:0]  qreg_q,  qreg_d;   // quotient shift register
   logic [3:0]  cnt_q,   cnt_d;    // iterations completed
   logic [7:0]  quo_q,   quo_d;
   logic [7:0]  rem_q,   rem_d;
   logic        done_q,  done_d;

   logic [15:0] dvsr_shift;
   logic        fits;
   logic [15:0] prem_next;
   logic [7:0]  qreg_next;

   // One restoring step: shift the divisor first, then trial-subtract.
   assign dvsr_shift = dvsr_q >> 1;
   assign fits       = (prem_q >= dvsr_shift);
   assign prem_next  = fits ? (prem_q - dvsr_shift) : prem_q;
   assign qreg_next  = {qreg_q[6:0], fits};

   // NOTE: every variable gets a default at the top of the block so that no
   // path leaves it unassigned; otherwise a latch is inferred.
   always_comb begin
      state_d = state_q;
      prem_d  = prem_q;
      dvsr_d  = dvsr_q;
      qreg_d  = qreg_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      done_d  = done_q;

      case (state_q)
         // The LOAD->BUSY edge already performs the first iteration, so the
         // 8th edge after reset completes the division.
         ST_LOAD, ST_BUSY: begin
            dvsr_d  = dvsr_shift;
            prem_d  = prem_next;
            qreg_d  = qreg_next;
            cnt_d   = cnt_q + 4'd1;
            state_d = ST_BUSY;
            if (cnt_q == 4'd7) begin
               // Outputs update only on entry to DONE: no partial result.
               state_d = ST_DONE;
               quo_d   = qreg_next;
               rem_d   = prem_next[7:0];
               done_d  = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its _d value from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_LOAD;
         prem_q  <= {8'b0, a};
         dvsr_q  <= {b, 8'b0};
         qreg_q  <= 8'b0;
         cnt_q   <= 4'd0;
         quo_q   <= 8'b0;
         rem_q   <= 8'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         prem_q  <= prem_d;
         dvsr_q  <= dvsr_d;
         qreg_q  <= qreg_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         done_q  <= done_d;
      end
   end

   assign quo  = quo_q;
   assign rem  = rem_q;
   assign done = done_q;

endmodule

// File: tb/tb_divider.sv
// -----------------------------------------------------------------------------
// tb_divider -- self-checking bench for divider.
// Expected results come from plain integer / and % (with the divide-by-zero
// rule), never from the design's outputs.
// -----------------------------------------------------------------------------
module tb_divider;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] a   = 8'd0;
   logic [7:0] b   = 8'd0;
   logic [7:0] quo;
   logic [7:0] rem;
   logic       done;

   int checks   = 0;
   int failures = 0;

   divider dut (
      .clk  (clk),
      .rst  (rst),
      .a    (a),
      .b    (b),
      .quo  (quo),
      .rem  (rem),
      .done (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ref_quo(input logic [7:0] av, input logic [7:0] bv);
      int q;
      q = (bv == 8'd0) ? 255 : int'(av) / int'(bv);
      return q[7:0];
   endfunction

   function automatic logic [7:0] ref_rem(input logic [7:0] av, input logic [7:0] bv);
      int r;
      r = (bv == 8'd0) ? int'(av) : int'(av) % int'(bv);
      return r[7:0];
   endfunction

   // One-cycle reset with (av, bv), then 8 edges with rst=0. Outputs must be
   // zero on every intermediate edge and correct on the 8th; then held.
   // With scramble set, a/b are changed while busy and must be ignored.
   task automatic run_div(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input bit scramble, input int hold_cycles);
      logic [7:0] eq, er;
      eq = ref_quo(av, bv);
      er = ref_rem(av, bv);
      @(negedge clk);
      rst = 1'b1; a = av; b = bv;
      @(negedge clk);
      check({tag, "_rst_done"}, {7'd0, done}, 8'd0);
      check({tag, "_rst_quo"}, quo, 8'd0);
      check({tag, "_rst_rem"}, rem, 8'd0);
      rst = 1'b0;
      if (scramble) begin
         a = 8'($urandom);
         b = 8'($urandom);
      end
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (scramble) begin
            a = 8'($urandom);
            b = 8'($urandom);
         end
         if (i < 8) begin
            check({tag, "_busy_done"}, {7'd0, done}, 8'd0);
            check({tag, "_busy_quo"}, quo, 8'd0);
            check({tag, "_busy_rem"}, rem, 8'd0);
         end else begin
            check({tag, "_done"}, {7'd0, done}, 8'd1);
            check({tag, "_quo"}, quo, eq);
            check({tag, "_rem"}, rem, er);
         end
      end
      for (int i = 0; i < hold_cycles; i++) begin
         @(negedge clk);
         a = 8'($urandom);
         b = 8'($urandom);
         check({tag, "_hold_done"}, {7'd0, done}, 8'd1);
         check({tag, "_hold_quo"}, quo, eq);
         check({tag, "_hold_rem"}, rem, er);
      end
   endtask

   initial begin
      logic [7:0] ra, rb;

      // Multi-cycle reset: the last rst edge's operands win.
      @(negedge clk);
      rst = 1'b1; a = 8'd99; b = 8'd4;
      @(negedge clk);
      a = 8'd50; b = 8'd3;
      @(negedge clk);
      check("por_done", {7'd0, done}, 8'd0);
      check("por_quo", quo, 8'd0);
      check("por_rem", rem, 8'd0);
      rst = 1'b0;
      repeat (7) @(negedge clk);
      check("last_wins_done0", {7'd0, done}, 8'd0);
      @(negedge clk);
      check("last_wins_quo", quo, 8'd16);
      check("last_wins_rem", rem, 8'd2);

      // Directed cases.
      run_div("d7_2",    8'd7,   8'd2, 1'b0, 1);
      run_div("d15_3",   8'd15,  8'd3, 1'b0, 1);
      run_div("d63_8",   8'd63,  8'd8, 1'b0, 1);
      run_div("d255_9",  8'd255, 8'd9, 1'b0, 1);
      run_div("d32_8",   8'd32,  8'd8, 1'b0, 5);
      run_div("d5_0",    8'd5,   8'd0, 1'b0, 2);
      run_div("d3_9",    8'd3,   8'd9, 1'b0, 1);
      run_div("d0_7",    8'd0,   8'd7, 1'b0, 1);
      run_div("d0_0",    8'd0,   8'd0, 1'b0, 1);
      run_div("d255_1",  8'd255, 8'd1, 1'b0, 1);
      run_div("d255_255",8'd255, 8'd255, 1'b0, 1);
      run_div("scramble",8'd77,  8'd6, 1'b1, 2);

      // Abort: start 200/7, reset on the 4th busy cycle with 100/10.
      @(negedge clk);
      rst = 1'b1; a = 8'd200; b = 8'd7;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort_busy_done", {7'd0, done}, 8'd0);
      end
      run_div("abort_new", 8'd100, 8'd10, 1'b0, 2);

      // Randomized operands, with divisor 0 forced now and then.
      for (int n = 0; n < 25; n++) begin
         ra = 8'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
         run_div("rand", ra, rb, n[0], 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter: none; operand and result width is fixed at 8 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high; also the start command for a new division.
REQ-004 a  input  8  dividend, unsigned.
REQ-005 b  input  8  divisor, unsigned.
REQ-006 quo  output  8  quotient, registered.
REQ-007 rem  output  8  remainder, registered.
REQ-008 done  output  1  high while quo/rem hold the valid result of the current operands.

Function
REQ-009 The block SHALL compute the unsigned restoring division a / b, one quotient bit per clock, MSB first.
REQ-010 Internal datapath SHALL consist of:
- a 16-bit partial-remainder register, loaded with {8'b0, a};
- a 16-bit divisor register, loaded with {b, 8'b0} and shifted right one bit per iteration;
- an 8-bit quotient shift register;
- a 4-bit iteration counter.
REQ-011 Each iteration SHALL do the following:
- shift the divisor right by 1;
- if partial remainder >= shifted divisor, subtract it and shift 1 into the quotient; otherwise shift 0 into the quotient.
REQ-012 The state machine SHALL have three states:
- LOAD: entered on any edge with rst=1;
- BUSY: entered on the first edge with rst=0, and runs 8 iterations;
- DONE: entered after the 8th iteration; the block holds there until rst.
REQ-013 Operands SHALL be sampled on the rising edge(s) where rst=1 (the last such edge wins); a and b changes while rst=0 SHALL be ignored.
REQ-014 Latency: done and the final quo/rem SHALL be valid after the 8th rising edge with rst=0 following reset, and no later than 9 edges after rst deasserts.
REQ-015 quo and rem SHALL read 0 and done SHALL be 0 throughout LOAD and BUSY, and update only when entering DONE.
REQ-016 In DONE, quo, rem and done=1 SHALL hold stable indefinitely until the next rst.
REQ-017 Invariants: in DONE, quo*b + rem == a and rem < b, for all b != 0.
REQ-018 Divide by zero (b=0) SHALL give quo=8'hFF, rem=a, done=1, with the same latency.
REQ-019 a < b SHALL give quo=0 and rem=a; a=0 SHALL give quo=0 and rem=0.
REQ-020 Reset asserted mid-operation (BUSY) or in DONE SHALL abort the operation, clear the outputs and reload the operands on that edge; no partial result SHALL appear.
REQ-021 No combinational path SHALL exist from a, b or rst to quo, rem or done.

Reset
REQ-022 On any rising edge with rst=1 the block SHALL:
- set quo=0, rem=0, done=0;
- clear the counter and the quotient register;
- load the remainder and divisor registers from a and b;
- enter LOAD.
REQ-023 Behaviour SHALL be deterministic from the first reset edge; no power-on initial values SHALL be required.

Verification
REQ-024 a=7, b=2, rst one cycle then low -> within 9 cycles done=1, quo=3, rem=1.
REQ-025 a=15, b=3 -> quo=5, rem=0; then a=63, b=8 -> quo=7, rem=7, each after a one-cycle reset.
REQ-026 a=255, b=9 -> quo=28, rem=3; then a=32, b=8 -> quo=4, rem=0; results held stable until the next reset.
REQ-027 a=5, b=0 -> quo=255, rem=5, done=1; a=3, b=9 -> quo=0, rem=3.
REQ-028 Start a=200, b=7, assert rst at the 4th BUSY cycle with a=100, b=10 -> done stays 0 until the new result; then quo=10, rem=0.
REQ-029 Change a and b while BUSY without rst -> result reflects the operands sampled at reset.
